std_reg_arbiter: RTL and testbench
==================================

STD_REG_ARBITER -- requirements
Module: std_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the data width of the shared register.
REQ-002 Parameter NUM_REQ, default 4, range 2..16, SHALL set the requester count.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 go  input  NUM_REQ  SHALL carry per-requester write requests, held high until the matching done.
REQ-006 in  input  NUM_REQ*WIDTH  SHALL carry packed write data; slice i holds bits [i*WIDTH +: WIDTH] and is held stable while go[i] is high.
REQ-007 done  output  NUM_REQ  SHALL carry per-requester one-cycle completion pulses.
REQ-008 reg_in  output  WIDTH  SHALL drive the shared register's data input.
REQ-009 reg_write_en  output  1  SHALL drive the shared register's write enable.
REQ-010 reg_done  input  1  SHALL be the shared register's done flag: high the cycle after a write.
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 owner  output  clog2(NUM_REQ)  SHALL show the index of the current grant holder, or the last one when idle.

Function
REQ-013 The FSM SHALL have four states: IDLE, WRITE, WAIT, ACK.
REQ-014 IDLE: if any go bit is high, the block SHALL latch the round-robin winner into owner and move to WRITE; otherwise it stays in IDLE.
REQ-015 Round-robin: the search SHALL start at index ptr, ascend, and wrap from NUM_REQ-1 to 0; the first set go bit wins.
REQ-016 After each grant to k, ptr SHALL become (k+1) mod NUM_REQ, updated on the IDLE->WRITE transition.
REQ-017 WRITE: reg_write_en SHALL be 1 for exactly this one cycle; reg_in = in slice[owner]; next state WAIT.
REQ-018 In every state except WRITE: reg_write_en SHALL be 0 and reg_in SHALL hold the last driven value.
REQ-019 WAIT: on reg_done=1 the FSM SHALL go to ACK; otherwise it stays in WAIT indefinitely (no timeout).
REQ-020 ACK: done[owner] SHALL be 1 for this one cycle, all other done bits 0; next state IDLE.
REQ-021 Minimum latency SHALL be: go sampled at cycle T -> reg_write_en at T+1 -> reg_done at T+2 -> done at T+3 -> IDLE at T+4.
REQ-022 At most one done bit SHALL be high in any cycle, and at most one write SHALL be outstanding.
REQ-023 If go[owner] drops after grant, the transaction SHALL still complete and done[owner] SHALL still pulse.
REQ-024 A go bit rising while busy SHALL be held pending and arbitrated at the next IDLE.
REQ-025 reg_done seen in IDLE or ACK SHALL be ignored.
REQ-026 A requester still asserting go in the IDLE cycle after its done SHALL be treated as a new request, at lowest priority.

Reset
REQ-027 On reset the block SHALL set: state=IDLE, ptr=0, owner=0, done=0, reg_write_en=0, reg_in=0, busy=0.
REQ-028 Reset mid-transaction SHALL abort without a done pulse; reset has priority over all transitions.

Structure
REQ-029 The shared package SHALL hold the FSM state enum (arb_state_t) and the owner-width constant function.
REQ-030 Winner selection SHALL be one combinational sub-module, rr_pick (inputs: req vector, ptr; outputs: winner index, any-valid).
REQ-031 The FSM, ptr, and output registers SHALL live in std_reg_arbiter; the shared register is external.

Verification
REQ-032 Bench SHALL pair the DUT with a WIDTH=2 register model whose done goes high one cycle after write_en; NUM_REQ=4.
REQ-033 Single request: go[2]=1, in[2]=2'b11 at T -> reg_write_en=1, reg_in=3 at T+1; done[2] at T+3; busy low at T+4.
REQ-034 All four go high, data 0,1,2,3, ptr=0 -> grant order 0,1,2,3; done pulses 4 cycles apart; register ends at 3.
REQ-035 Wrap: ptr=3, go[3]=go[0]=1 -> 3 granted first, then 0; ptr=1 afterwards.
REQ-036 Reset during WAIT -> next cycle IDLE, ptr=0, no done pulse; a held go[1] is then granted with normal latency.
REQ-037 Stalled reg_done held low 10 cycles in WAIT -> reg_write_en stays 0, busy stays 1; done follows 1 cycle after reg_done rises.

Source files
------------

// File: rtl/std_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package std_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StWait,
      StAck
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned owner_width(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/std_reg_arbiter_if.sv
// Requester and shared-register signals of the arbiter, bundled.
interface std_reg_arbiter_if
   import std_reg_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned NUM_REQ = 4
);

   localparam int unsigned OwnerW = owner_width(NUM_REQ);

   logic [NUM_REQ-1:0]       go;
   logic [NUM_REQ*WIDTH-1:0] in;
   logic [NUM_REQ-1:0]       done;
   logic [WIDTH-1:0]         reg_in;
   logic                     reg_write_en;
   logic                     reg_done;
   logic                     busy;
   logic [OwnerW-1:0]        owner;

   // Arbiter side.
   modport slave (
      input  go, in, reg_done,
      output done, reg_in, reg_write_en, busy, owner
   );

   // Requesters plus shared register side.
   modport master (
      output go, in, reg_done,
      input  done, reg_in, reg_write_en, busy, owner
   );

endinterface

// File: rtl/std_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module std_reg_arbiter_rr_pick
   import std_reg_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned OwnerW = owner_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OwnerW-1:0]  ptr,
   output logic [OwnerW-1:0]  winner,
   output logic               any_valid
);

   int idx;

   // Scan offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      winner    = '0;
      any_valid = |req;
      idx       = 0;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % int'(NUM_REQ);
         if (req[idx]) begin
            winner = OwnerW'(idx);
         end
      end
   end

endmodule

// File: rtl/std_reg_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared register.
module std_reg_arbiter
   import std_reg_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned NUM_REQ = 4
) (
   input logic               clk,
   input logic               reset,
   std_reg_arbiter_if.slave  bus
);

   localparam int unsigned OwnerW = owner_width(NUM_REQ);

   arb_state_t         state_q;
   logic [OwnerW-1:0]  ptr_q;
   logic [OwnerW-1:0]  owner_q;
   logic [NUM_REQ-1:0] done_q;
   logic [WIDTH-1:0]   reg_in_q;
   logic               reg_write_en_q;
   logic [OwnerW-1:0]  winner;
   logic               any_valid;

   std_reg_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req       (bus.go),
      .ptr       (ptr_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // Arbitration FSM; all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         ptr_q          <= '0;
         owner_q        <= '0;
         done_q         <= '0;
         reg_in_q       <= '0;
         reg_write_en_q <= 1'b0;
      end else begin
         // Pulses default low; reg_in_q keeps its last driven value.
         reg_write_en_q <= 1'b0;
         done_q         <= '0;
         case (state_q)
            StIdle: begin
               if (any_valid) begin
                  owner_q        <= winner;
                  ptr_q          <= (winner == OwnerW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                  reg_in_q       <= bus.in[winner*WIDTH +: WIDTH];
                  reg_write_en_q <= 1'b1;
                  state_q        <= StWrite;
               end
            end
            StWrite: state_q <= StWait;
            StWait: begin
               if (bus.reg_done) begin
                  done_q[owner_q] <= 1'b1;
                  state_q         <= StAck;
               end
            end
            StAck:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.done         = done_q;
   assign bus.reg_in       = reg_in_q;
   assign bus.reg_write_en = reg_write_en_q;
   assign bus.busy         = (state_q != StIdle);
   assign bus.owner        = owner_q;

endmodule

// File: tb/tb_std_reg_arbiter.sv
// Scoreboard bench for std_reg_arbiter with a one-cycle-latency register model.
module tb_std_reg_arbiter;

   localparam int W = 2;
   localparam int N = 4;

   typedef struct {
      int owner;
      int data;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic stall = 1'b0;
   logic pend;
   logic [W-1:0] reg_val;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   wr_t        exp_wr[$];
   logic [3:0] exp_done[$];
   int         done_times[$];
   wr_t        e_wr;

   always #5 clk = ~clk;

   std_reg_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

   std_reg_arbiter #(
      .WIDTH   (W),
      .NUM_REQ (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Shared register model: done one cycle after write_en, optionally stalled.
   always @(posedge clk) begin
      if (reset) begin
         pend    <= 1'b0;
         reg_val <= '0;
      end else if (bus.reg_write_en) begin
         pend    <= 1'b1;
         reg_val <= bus.reg_in;
      end else if (bus.reg_done) begin
         pend <= 1'b0;
      end
   end
   assign bus.reg_done = pend & ~stall;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_txn(input int owner, input int data, input bit with_done);
      exp_wr.push_back('{owner, data});
      if (with_done) exp_done.push_back(4'b0001 << owner);
   endtask

   // Run until idle; requesters drop go on their done unless listed in keep (once).
   task automatic drain(input logic [3:0] keep_in, input int budget);
      logic [3:0] keep;
      int         cycles;
      keep   = keep_in;
      cycles = 0;
      while ((bus.go != 0 || bus.busy) && cycles < budget) begin
         tick();
         cycles++;
         for (int i = 0; i < N; i++) begin
            if (bus.done[i]) begin
               if (keep[i]) keep[i] = 1'b0;
               else bus.go[i] = 1'b0;
            end
         end
      end
      if (cycles >= budget) check("drain_timeout_go", bus.go, 0);
      check("drain_busy", bus.busy, 0);
   endtask

   // Monitor: compare every write and done pulse against the expected queues.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (bus.reg_write_en !== 1'b0) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_write", bus.reg_write_en, 0);
            end else begin
               e_wr = exp_wr.pop_front();
               check("write_owner", bus.owner, e_wr.owner);
               check("write_data", bus.reg_in, e_wr.data);
            end
         end
         if (bus.done !== 4'b0000) begin
            done_times.push_back(cyc);
            if (exp_done.size() == 0) check("unexpected_done", bus.done, 0);
            else check("done_vector", bus.done, exp_done.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.go = '0;
      bus.in = '0;
      repeat (3) tick();

      // Reset state.
      check("rst_busy", bus.busy, 0);
      check("rst_owner", bus.owner, 0);
      check("rst_done", bus.done, 0);
      check("rst_we", bus.reg_write_en, 0);
      check("rst_reg_in", bus.reg_in, 0);
      reset = 1'b0;
      tick();
      check("idle_no_go", bus.busy, 0);

      // Single request with minimum latency.
      bus.in = 8'b00_11_00_00;
      bus.go = 4'b0100;
      expect_txn(2, 3, 1);
      tick();
      check("single_we", bus.reg_write_en, 1);
      check("single_busy", bus.busy, 1);
      tick();
      check("single_we_once", bus.reg_write_en, 0);
      tick();
      check("single_done", bus.done, 4'b0100);
      bus.go = '0;
      tick();
      check("single_idle", bus.busy, 0);
      check("single_done_clear", bus.done, 0);

      // All four from ptr=0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.in = 8'b11_10_01_00;
      bus.go = 4'b1111;
      for (int i = 0; i < N; i++) expect_txn(i, i, 1);
      done_times.delete();
      drain(4'b0000, 60);
      check("rr_done_count", done_times.size(), 4);
      if (done_times.size() == 4) begin
         for (int i = 1; i < 4; i++) check("rr_done_gap", done_times[i] - done_times[i-1], 4);
      end
      check("rr_reg_final", reg_val, 3);

      // Move ptr to 3.
      bus.in = 8'b00_01_00_00;
      bus.go = 4'b0100;
      expect_txn(2, 1, 1);
      drain(4'b0000, 20);

      // Wrap: 3 before 0, leaving ptr=1.
      bus.in = 8'b10_00_00_01;
      bus.go = 4'b1001;
      expect_txn(3, 2, 1);
      expect_txn(0, 1, 1);
      drain(4'b0000, 30);

      // ptr=1 shows as 1 winning over 0.
      bus.in = 8'b00_00_00_11;
      bus.go = 4'b0011;
      expect_txn(1, 0, 1);
      expect_txn(0, 3, 1);
      drain(4'b0000, 30);

      // go dropped right after grant still completes.
      bus.in = 8'b00_00_10_00;
      bus.go = 4'b0010;
      expect_txn(1, 2, 1);
      tick();
      check("drop_we", bus.reg_write_en, 1);
      bus.go = '0;
      drain(4'b0000, 20);

      // ptr=2: requester 2 keeps go after done and drops to lowest priority.
      bus.in = 8'b00_10_00_01;
      bus.go = 4'b0101;
      expect_txn(2, 2, 1);
      expect_txn(0, 1, 1);
      expect_txn(2, 2, 1);
      drain(4'b0100, 40);

      // ptr=3: reset during WAIT aborts; ptr returns to 0 so 1 beats 3.
      bus.in = 8'b11_00_01_00;
      bus.go = 4'b1010;
      expect_txn(3, 3, 0);
      tick();
      tick();
      check("abort_busy_wait", bus.busy, 1);
      reset = 1'b1;
      tick();
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_owner", bus.owner, 0);
      reset = 1'b0;
      expect_txn(1, 1, 1);
      expect_txn(3, 3, 1);
      tick();
      check("abort_regrant_we", bus.reg_write_en, 1);
      check("abort_regrant_owner", bus.owner, 1);
      drain(4'b0000, 30);

      // Stalled register done.
      bus.in = 8'b00_00_00_10;
      bus.go = 4'b0001;
      stall  = 1'b1;
      expect_txn(0, 2, 1);
      tick();
      check("stall_first_we", bus.reg_write_en, 1);
      repeat (10) begin
         tick();
         check("stall_we", bus.reg_write_en, 0);
         check("stall_busy", bus.busy, 1);
         check("stall_done", bus.done, 0);
      end
      stall = 1'b0;
      tick();
      check("stall_done_pulse", bus.done, 4'b0001);
      bus.go = '0;
      tick();
      check("stall_idle", bus.busy, 0);

      tick();
      check("left_writes", exp_wr.size(), 0);
      check("left_dones", exp_done.size(), 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
